// File: rtl/zap_cp_responder.sv
// zap_cp_responder: coprocessor-side MCR/MRC responder holding CR0..CR15 and
// accessing the CPU register file through a dedicated port.
module zap_cp_responder #(
  parameter logic [3:0]  CP_NUM = 4'd15,
  parameter logic [31:0] CP_ID  = 32'h4100_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dav,
  input  logic [31:0] i_word,
  input  logic [4:0]  i_cpsr_mode,
  output logic        o_done,
  output logic        o_undef,
  output logic        o_reg_en,
  output logic        o_reg_wr_en,
  output logic [5:0]  o_reg_index,
  output logic [31:0] o_reg_wr_data,
  input  logic [31:0] i_reg_rd_data,
  output logic [31:0] o_cr1
);
  typedef enum logic [2:0] {IDLE, MCR_RD, MCR_CAP, MRC_WR, DONE, WAIT_DROP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  crn_q, rd_q;
  logic        rej_q, done_q, undef_q, accept;
  logic [31:0] cr_q [16];
  // MRC into R15 would target the PC/flags path, which this block does not support
  assign accept = i_word[27:24] == 4'b1110 && i_word[4] && i_word[11:8] == CP_NUM &&
                  i_cpsr_mode != 5'b10000 && !(i_word[20] && &i_word[15:12]);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = !i_dav ? IDLE : !accept ? DONE : i_word[20] ? MRC_WR : MCR_RD;
      MCR_RD:    state_d = MCR_CAP;
      MCR_CAP:   state_d = DONE;
      MRC_WR:    state_d = DONE;
      DONE:      state_d = WAIT_DROP;
      WAIT_DROP: state_d = i_dav ? WAIT_DROP : IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      crn_q    <= '0;
      rd_q     <= '0;
      rej_q    <= 1'b0;
      done_q   <= 1'b0;
      undef_q  <= 1'b0;
      cr_q[0]  <= CP_ID;
      for (int i = 1; i < 16; i++) cr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && i_dav) begin
        crn_q <= i_word[19:16];
        rd_q  <= i_word[15:12];
        rej_q <= !accept;
      end
      if (state_q == MCR_CAP && crn_q != 4'd0) cr_q[crn_q] <= i_reg_rd_data;
      done_q  <= state_q == DONE;
      undef_q <= state_q == DONE && rej_q;
    end
  end
  assign o_reg_en      = state_q == MCR_RD || state_q == MRC_WR;
  assign o_reg_wr_en   = state_q == MRC_WR;
  assign o_reg_index   = o_reg_en ? {2'b00, rd_q} : 6'd0;
  assign o_reg_wr_data = o_reg_wr_en ? cr_q[crn_q] : 32'd0;
  assign o_done        = done_q;
  assign o_undef       = undef_q;
  assign o_cr1         = cr_q[1];
endmodule

// File: tb/tb_zap_cp_responder.sv
// tb_zap_cp_responder: scoreboard bench for the MCR/MRC responder with a
// behavioural CPU register file answering reads one cycle late.
module tb_zap_cp_responder;
  logic        clk = 1'b0, i_reset = 1'b1, i_dav = 1'b0;
  logic [31:0] i_word = '0, i_reg_rd_data = '0;
  logic [4:0]  i_cpsr_mode = 5'b10011;
  logic        o_done, o_undef, o_reg_en, o_reg_wr_en;
  logic [5:0]  o_reg_index;
  logic [31:0] o_reg_wr_data, o_cr1;
  int          cyc = 0, checks = 0, errors = 0;
  logic [31:0] rf [16];
  logic [31:0] cr_m [16];
  typedef struct {
    logic        is_done;
    logic        undef;
    logic        wr;
    logic [5:0]  idx;
    logic [31:0] data;
    int          cyc;
  } ev_t;
  ev_t sb[$];
  ev_t e;
  localparam logic [4:0] SVC = 5'b10011, USR = 5'b10000;

  zap_cp_responder dut (
    .i_clk(clk), .i_reset(i_reset), .i_dav(i_dav), .i_word(i_word),
    .i_cpsr_mode(i_cpsr_mode), .o_done(o_done), .o_undef(o_undef),
    .o_reg_en(o_reg_en), .o_reg_wr_en(o_reg_wr_en), .o_reg_index(o_reg_index),
    .o_reg_wr_data(o_reg_wr_data), .i_reg_rd_data(i_reg_rd_data), .o_cr1(o_cr1)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CPU register file: read data appears only in the cycle after the read request
  initial begin
    logic       prev_rd;
    logic [3:0] prev_idx;
    prev_rd = 1'b0;
    prev_idx = '0;
    forever begin
      @(negedge clk);
      i_reg_rd_data = prev_rd ? rf[prev_idx] : 32'hBAD0_BAD0;
      prev_rd = o_reg_en && !o_reg_wr_en;
      prev_idx = o_reg_index[3:0];
    end
  end

  always @(negedge clk) begin
    if (o_reg_en) begin
      if (sb.size() == 0) chk("unexp_acc", o_reg_en, 0);
      else begin
        e = sb.pop_front();
        chk("acc_kind", e.is_done, 0);
        chk("acc_cyc", cyc, e.cyc);
        chk("acc_wr", o_reg_wr_en, e.wr);
        chk("acc_idx", o_reg_index, e.idx);
        if (e.wr) chk("acc_data", o_reg_wr_data, e.data);
      end
    end
    if (o_done) begin
      if (sb.size() == 0) chk("unexp_done", o_done, 0);
      else begin
        e = sb.pop_front();
        chk("done_kind", e.is_done, 1);
        chk("done_cyc", cyc, e.cyc);
        chk("done_undef", o_undef, e.undef);
      end
    end else if (o_undef) chk("undef_alone", o_undef, 0);
  end

  task automatic model_reset();
    cr_m[0] = 32'h4100_0000;
    for (int i = 1; i < 16; i++) cr_m[i] = '0;
  endtask

  task automatic push(input logic d, input logic u, input logic w, input logic [3:0] idx,
                      input logic [31:0] data, input int c);
    ev_t x;
    x.is_done = d; x.undef = u; x.wr = w; x.idx = {2'b00, idx}; x.data = data; x.cyc = c;
    sb.push_back(x);
  endtask

  task automatic do_req(input logic [31:0] w, input logic [4:0] m, input int hold);
    logic ok;
    int   n;
    @(negedge clk);
    ok = w[27:24] == 4'hE && w[4] && w[11:8] == 4'hF && m != USR && !(w[20] && w[15:12] == 4'hF);
    n = cyc;
    if (!ok) push(1, 1, 0, 0, 0, n + 2);
    else if (w[20]) begin
      push(0, 0, 1, w[15:12], cr_m[w[19:16]], n + 1);
      push(1, 0, 0, 0, 0, n + 3);
    end else begin
      push(0, 0, 0, w[15:12], 0, n + 1);
      push(1, 0, 0, 0, 0, n + 4);
      if (w[19:16] != 4'd0) cr_m[w[19:16]] = rf[w[15:12]];
    end
    i_word = w;
    i_cpsr_mode = m;
    i_dav = 1'b1;
    for (int i = 0; i < 12 && !o_done; i++) @(negedge clk);
    chk("done_seen", o_done, 1);
    for (int i = 0; i < hold; i++) @(negedge clk);
    i_dav = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) rf[i] = 32'h1000_0000 + i * 32'h0111_0101;
    rf[3] = 32'h0000_1005;
    rf[7] = 32'hDEAD_BEEF;
    model_reset();
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    chk("rst_done", o_done, 0);
    chk("rst_undef", o_undef, 0);
    chk("rst_en", o_reg_en, 0);
    chk("rst_cr1", o_cr1, 0);
    do_req(32'hEE01_3F10, SVC, 0);
    chk("cr1_mcr", o_cr1, 32'h0000_1005);
    do_req(32'hEE10_5F10, SVC, 0);
    do_req(32'hEE00_7F10, SVC, 0);
    do_req(32'hEE10_5F10, SVC, 0);
    do_req(32'hEE01_3E10, SVC, 0);
    do_req(32'hEE01_3F10, USR, 0);
    do_req(32'hEE10_FF10, SVC, 0);
    do_req(32'hEE01_3F00, SVC, 0);
    do_req(32'hEE09_7F10, SVC, 0);
    do_req(32'hEE19_2F10, SVC, 5);
    do_req(32'hEE11_4F10, SVC, 0);
    // reset lands while the read data is being captured
    rf[3] = 32'h5555_AAAA;
    @(negedge clk);
    n = cyc;
    push(0, 0, 0, 4'd3, 0, n + 1);
    i_word = 32'hEE01_3F10;
    i_cpsr_mode = SVC;
    i_dav = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
    i_dav = 1'b0;
    @(negedge clk);
    i_reset = 1'b0;
    model_reset();
    chk("abort_done", o_done, 0);
    chk("abort_cr1", o_cr1, 0);
    repeat (3) @(negedge clk);
    do_req(32'hEE11_6F10, SVC, 0);
    do_req(32'hEE01_3F10, SVC, 0);
    chk("cr1_after", o_cr1, 32'h5555_AAAA);
    do_req(32'hEE10_1F10, SVC, 0);
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/zap_cp_responder.md
Name: zap_cp_responder

Overview:
- Coprocessor-side responder for the decode-stage coprocessor handshake (dav + 32-bit word in, done out).
- Holds 16 x 32-bit coprocessor registers (CR0..CR15).
- Executes MCR/MRC by accessing the CPU register file through a dedicated port.
- Rejects everything else (CDP/LDC/STC, wrong coprocessor number, user mode, Rd=15 MRC) with done + undef.

Parameters:
- CP_NUM, 15, coprocessor number this block answers to (compared with word[11:8]).
- CP_ID, 32'h4100_0000, reset/read-only value of CR0.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_dav  in  1  coprocessor request valid; held high by the initiator until it samples o_done.
- i_word  in  32  full coprocessor instruction; stable while i_dav=1.
- i_cpsr_mode  in  5  current CPU mode; 5'b10000 = user.
- o_done  out  1  one-cycle completion pulse (registered).
- o_undef  out  1  qualifies o_done: instruction rejected, raise undefined exception.
- o_reg_en  out  1  CPU register file access enable.
- o_reg_wr_en  out  1  1 = write, 0 = read (valid when o_reg_en=1).
- o_reg_index  out  6  CPU register index = {2'b00, Rd}; Rd = word[15:12].
- o_reg_wr_data  out  32  write data for MRC.
- i_reg_rd_data  in  32  read data, valid exactly one cycle after o_reg_en=1, o_reg_wr_en=0.
- o_cr1  out  32  live copy of CR1 (control register) for the core.

Behaviour:
- Reset: state=IDLE; all outputs 0; CR0=CP_ID; CR1..CR15=0. Reset mid-transaction aborts it with no done and no register write.
- Latched fields at acceptance: CRn=word[19:16], Rd=word[15:12], L=word[20].
- States:
  - IDLE:
    - If i_dav=1, latch i_word and classify.
    - MCR (word[27:24]=4'b1110, word[4]=1, L=0) -> MCR_RD.
    - MRC (same pattern, L=1) -> MRC_WR.
    - Any other encoding, word[11:8]!=CP_NUM, i_cpsr_mode=user, or MRC with Rd=15 -> DONE with undef=1.
  - MCR_RD: o_reg_en=1, o_reg_wr_en=0, o_reg_index={2'b00, Rd} for one cycle -> MCR_CAP.
  - MCR_CAP: write i_reg_rd_data to CR[CRn] -> DONE.
    - CRn=0: write is ignored (read-only); no undef.
    - CRn=1: o_cr1 updates in the same cycle as the write.
  - MRC_WR: o_reg_en=1, o_reg_wr_en=1, o_reg_index={2'b00, Rd}, o_reg_wr_data=CR[CRn] for one cycle -> DONE.
  - DONE: o_done=1 for exactly one cycle; o_undef=1 only if rejected -> WAIT_DROP.
  - WAIT_DROP:
    - Stay while i_dav=1: the initiator may hold dav through its own stalls, and the same request must never be re-executed.
    - When i_dav=0, go to IDLE.
- Latencies from the first i_dav=1 cycle in IDLE to o_done: MCR 4 cycles; MRC 3 cycles; undef 2 cycles.
- o_reg_en is never asserted outside MCR_RD/MRC_WR.
- o_undef=1 is never accompanied by a register file access.
- i_dav dropping before done (initiator cleared by writeback/ALU flush): the transaction runs to completion.
  - An MCR side effect is kept; the done pulse is harmless because the initiator ignores it when idle.
  - Next state after DONE is WAIT_DROP, which exits immediately since i_dav=0.
- Back-to-back requests: a new request is accepted only from IDLE, i.e. at least one i_dav=0 cycle between transactions.
- All registers are updated on the rising edge of i_clk; no combinational path from i_dav to o_done.

Test Plan:
- MCR p15, CR1 <- R3 (i_word=32'hEE01_3F10, mode=SVC, i_reg_rd_data=32'h0000_1005 one cycle after read) -> o_reg_index=3 read, o_cr1=32'h0000_1005, o_done pulse 4 cycles after dav, o_undef=0.
- MRC p15, R5 <- CR0 (i_word=32'hEE10_5F10) -> o_reg_en=o_reg_wr_en=1, o_reg_index=5, o_reg_wr_data=32'h4100_0000, then o_done, o_undef=0.
- MCR to CR0 with data 32'hDEAD_BEEF -> done, CR0 still 32'h4100_0000 on a following MRC.
- Wrong coprocessor (word[11:8]=14), then user-mode MCR p15, then MRC Rd=15 -> each gives o_done=o_undef=1 with no o_reg_en pulse.
- i_dav held high 5 cycles after o_done -> exactly one done pulse, no second register access; i_dav low 1 cycle then new MRC is accepted.
- i_reset asserted in MCR_CAP -> no CR write, o_done=0, CR1=0, state IDLE; subsequent MCR completes normally.
